// File: rtl/sdram_seq_pkg.sv
// Shared types for the SDRAM init/refresh sequencer: command encoding and FSM states.
package sdram_seq_pkg;

    typedef struct packed {
        logic cs_n;
        logic ras_n;
        logic cas_n;
        logic we_n;
    } sdr_cmd_t;

    localparam sdr_cmd_t CMD_NOP = 4'b1111;
    localparam sdr_cmd_t CMD_PRE = 4'b0010;
    localparam sdr_cmd_t CMD_REF = 4'b0001;
    localparam sdr_cmd_t CMD_LMR = 4'b0000;

    typedef enum logic [3:0] {
        PWRUP, PRE, WAIT_RP, REF, WAIT_RFC, LMR, WAIT_MRD, IDLE, R_REF, R_WAIT
    } seq_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sdram_seq_timer.sv
// Loadable down-counter with zero flag; parks at zero until reloaded.
module sdram_seq_timer #(
    parameter int W       = 10,
    parameter int RST_VAL = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset)
            cnt <= W'(RST_VAL);
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/sdram_init_refresh_sequencer.sv
// SDRAM power-up init sequencer with auto-refresh scheduling.
// Periodic refresh is built only when SDRAM_PERIODIC_REFRESH_EN is defined.
module sdram_init_refresh_sequencer
    import sdram_seq_pkg::*;
#(
    parameter int                T_PWR_CYC    = 505,
    parameter int                T_RP         = 2,
    parameter int                T_RFC        = 7,
    parameter int                N_INIT_REF   = 2,
    parameter int                T_MRD        = 2,
    parameter int                ADDR_W       = 13,
    parameter logic [ADDR_W-1:0] MODE_REG     = 13'h033,
    parameter int                REF_INTERVAL = 780
) (
    input  logic              clk,
    input  logic              reset,
    output logic              sdr_cs_n,
    output logic              sdr_ras_n,
    output logic              sdr_cas_n,
    output logic              sdr_we_n,
    output logic [ADDR_W-1:0] sdr_addr,
    output logic [1:0]        sdr_ba,
    output logic              sdr_init_done,
    output logic              ref_req,
    input  logic              ref_gnt,
    output logic              seq_busy,
    output logic              ref_overrun
);

    localparam int TMR_W  = $clog2(max3(T_PWR_CYC, T_RFC, REF_INTERVAL) + 1);
    localparam int NREF_W = $clog2(N_INIT_REF + 1);
    localparam logic [ADDR_W-1:0] ADDR_PRE_ALL = ADDR_W'(1 << 10);

    seq_state_t        state, state_next;
    sdr_cmd_t          cmd_q, cmd_next;
    logic [ADDR_W-1:0] addr_next;
    logic              tmr_load, tmr_zero;
    logic [TMR_W-1:0]  tmr_val;
    logic [NREF_W-1:0] init_ref_cnt;
    logic              ref_grant;

    sdram_seq_timer #(.W(TMR_W), .RST_VAL(T_PWR_CYC)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_next = state;
        tmr_load   = 1'b0;
        tmr_val    = '0;
        cmd_next   = CMD_NOP;
        addr_next  = '0;
        case (state)
            PWRUP:    if (tmr_zero) state_next = PRE;
            PRE:      begin tmr_load = 1'b1; tmr_val = TMR_W'(T_RP - 1);  state_next = WAIT_RP;  end
            WAIT_RP:  if (tmr_zero) state_next = REF;
            REF:      begin tmr_load = 1'b1; tmr_val = TMR_W'(T_RFC - 1); state_next = WAIT_RFC; end
            WAIT_RFC: if (tmr_zero)
                          state_next = (init_ref_cnt == NREF_W'(N_INIT_REF)) ? LMR : REF;
            LMR:      begin tmr_load = 1'b1; tmr_val = TMR_W'(T_MRD - 1); state_next = WAIT_MRD; end
            WAIT_MRD: if (tmr_zero) state_next = IDLE;
            IDLE:     if (ref_grant) state_next = R_REF;
            R_REF:    begin tmr_load = 1'b1; tmr_val = TMR_W'(T_RFC - 1); state_next = R_WAIT;   end
            R_WAIT:   if (tmr_zero) state_next = IDLE;
            default:  state_next = PWRUP;
        endcase
        // Outputs are registered from the state being entered so they line up with it.
        case (state_next)
            PRE:        begin cmd_next = CMD_PRE; addr_next = ADDR_PRE_ALL; end
            REF, R_REF: cmd_next = CMD_REF;
            LMR:        begin cmd_next = CMD_LMR; addr_next = MODE_REG; end
            default:    ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= PWRUP;
            cmd_q         <= CMD_NOP;
            sdr_addr      <= '0;
            sdr_init_done <= 1'b0;
            seq_busy      <= 1'b1;
            init_ref_cnt  <= '0;
        end else begin
            state         <= state_next;
            cmd_q         <= cmd_next;
            sdr_addr      <= addr_next;
            sdr_init_done <= sdr_init_done | (state_next == IDLE);
            seq_busy      <= (state_next != IDLE);
            if (state == REF)
                init_ref_cnt <= init_ref_cnt + 1'b1;
        end
    end

    assign {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} = cmd_q;
    assign sdr_ba = 2'b00;

`ifdef SDRAM_PERIODIC_REFRESH_EN
    localparam int REF_W = $clog2(REF_INTERVAL);

    logic [REF_W-1:0] ref_cnt;
    logic             ref_expire;

    // Expiry fires on the edge the counter lands on REF_INTERVAL-1, so ref_req rises with it.
    assign ref_expire = sdr_init_done && (ref_cnt == REF_W'(REF_INTERVAL - 2));
    assign ref_grant  = (state == IDLE) && ref_req && ref_gnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            ref_cnt     <= '0;
            ref_req     <= 1'b0;
            ref_overrun <= 1'b0;
        end else begin
            if (!sdr_init_done || ref_cnt == REF_W'(REF_INTERVAL - 1))
                ref_cnt <= '0;
            else
                ref_cnt <= ref_cnt + 1'b1;
            if (ref_expire) begin
                ref_req <= 1'b1;
                if (ref_req && !ref_grant)
                    ref_overrun <= 1'b1;
            end else if (ref_grant) begin
                ref_req <= 1'b0;
            end
        end
    end
`else
    logic unused_ref_gnt;

    assign unused_ref_gnt = ref_gnt;
    assign ref_grant      = 1'b0;
    assign ref_req        = 1'b0;
    assign ref_overrun    = 1'b0;
`endif

endmodule

// File: tb/tb_sdram_init_refresh_sequencer.sv
// Directed self-checking bench for the SDRAM init/refresh sequencer.
module tb_sdram_init_refresh_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        ref_gnt = 1'b0;
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;

    logic        cs_n, ras_n, cas_n, we_n, init_done, ref_req, seq_busy, ref_overrun;
    logic [12:0] addr;
    logic [1:0]  ba;
    logic        b_cs_n, b_ras_n, b_cas_n, b_we_n, b_init_done, b_ref_req, b_seq_busy, b_ref_overrun;
    logic [12:0] b_addr;
    logic [1:0]  b_ba;

    sdram_init_refresh_sequencer dut (
        .clk(clk), .reset(reset),
        .sdr_cs_n(cs_n), .sdr_ras_n(ras_n), .sdr_cas_n(cas_n), .sdr_we_n(we_n),
        .sdr_addr(addr), .sdr_ba(ba), .sdr_init_done(init_done),
        .ref_req(ref_req), .ref_gnt(ref_gnt), .seq_busy(seq_busy), .ref_overrun(ref_overrun)
    );

    sdram_init_refresh_sequencer #(.N_INIT_REF(8), .T_RFC(3)) dut8 (
        .clk(clk), .reset(reset),
        .sdr_cs_n(b_cs_n), .sdr_ras_n(b_ras_n), .sdr_cas_n(b_cas_n), .sdr_we_n(b_we_n),
        .sdr_addr(b_addr), .sdr_ba(b_ba), .sdr_init_done(b_init_done),
        .ref_req(b_ref_req), .ref_gnt(ref_gnt), .seq_busy(b_seq_busy), .ref_overrun(b_ref_overrun)
    );

    wire [3:0] cmd  = {cs_n, ras_n, cas_n, we_n};
    wire [3:0] cmd8 = {b_cs_n, b_ras_n, b_cas_n, b_we_n};

    localparam logic [3:0] NOP = 4'b1111, PREC = 4'b0010, AREF = 4'b0001, LMRC = 4'b0000;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s @cycle %0d: observed 0x%0h expected 0x%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " cmd"},  32'(cmd), 32'(NOP));
        check({tag, " addr"}, 32'(addr), 32'h0);
        check({tag, " ba"},   32'(ba), 32'h0);
        check({tag, " done"}, 32'(init_done), 32'h0);
        check({tag, " req"},  32'(ref_req), 32'h0);
        check({tag, " busy"}, 32'(seq_busy), 32'h1);
        check({tag, " ovr"},  32'(ref_overrun), 32'h0);
    endtask

    // Hand-derived init timeline: PRE at 505, first REF at 508, REFs every 1+T_RFC.
    function automatic logic [3:0] exp_cmd(input int c, input int nref, input int trfc);
        int lmr;
        lmr = 508 + nref * (1 + trfc);
        if (c == 505) return PREC;
        if (c >= 508 && c < lmr && ((c - 508) % (1 + trfc)) == 0) return AREF;
        if (c == lmr) return LMRC;
        return NOP;
    endfunction

    function automatic logic [12:0] exp_addr(input logic [3:0] c);
        if (c == PREC) return 13'h400;
        if (c == LMRC) return 13'h033;
        return 13'h000;
    endfunction

    initial begin
        int nref;
        int bad;

        // Reset held for a few edges, then released; next edge is cycle 0.
        repeat (3) tick();
        check_reset_vals("rst0");
        reset = 1'b0;
        cyc   = -1;
        ref_gnt = 1'b1;

        // Init scan for both parameterisations, cycle by cycle.
        for (int c = 0; c <= 545; c++) begin
            tick();
            check($sformatf("cmd@%0d", cyc),   32'(cmd),  32'(exp_cmd(cyc, 2, 7)));
            check($sformatf("addr@%0d", cyc),  32'(addr), 32'(exp_addr(exp_cmd(cyc, 2, 7))));
            check($sformatf("done@%0d", cyc),  32'(init_done), (cyc >= 527) ? 32'h1 : 32'h0);
            check($sformatf("busy@%0d", cyc),  32'(seq_busy),  (cyc >= 527) ? 32'h0 : 32'h1);
            check($sformatf("req@%0d", cyc),   32'(ref_req), 32'h0);
            check($sformatf("cmd8@%0d", cyc),  32'(cmd8), 32'(exp_cmd(cyc, 8, 3)));
            check($sformatf("addr8@%0d", cyc), 32'(b_addr), 32'(exp_addr(exp_cmd(cyc, 8, 3))));
            check($sformatf("done8@%0d", cyc), 32'(b_init_done), (cyc >= 543) ? 32'h1 : 32'h0);
        end

`ifdef SDRAM_PERIODIC_REFRESH_EN
        // Grant held high: request at 527+779, REF one cycle later, 8 busy cycles.
        run_to(1305);
        check("req_before", 32'(ref_req), 32'h0);
        tick();
        check("req_rise", 32'(ref_req), 32'h1);
        check("req_rise_cmd", 32'(cmd), 32'(NOP));
        check("req_rise_busy", 32'(seq_busy), 32'h0);
        tick();
        check("ref_cmd", 32'(cmd), 32'(AREF));
        check("ref_req_drop", 32'(ref_req), 32'h0);
        check("ref_busy", 32'(seq_busy), 32'h1);
        for (int i = 0; i < 7; i++) begin
            tick();
            check("rfc_busy", 32'(seq_busy), 32'h1);
            check("rfc_nop", 32'(cmd), 32'(NOP));
        end
        tick();
        check("rfc_end_busy", 32'(seq_busy), 32'h0);

        // Counter is free-running: next request 780 cycles after the first.
        run_to(2085);
        check("req2_before", 32'(ref_req), 32'h0);
        tick();
        check("req2_rise", 32'(ref_req), 32'h1);
        tick();
        check("ref2_cmd", 32'(cmd), 32'(AREF));

        // Grant withheld: request at 2866, overrun at the following expiry.
        run_to(2100);
        ref_gnt = 1'b0;
        run_to(2866);
        check("req3_rise", 32'(ref_req), 32'h1);
        run_to(3645);
        check("ovr_before", 32'(ref_overrun), 32'h0);
        tick();
        check("ovr_set", 32'(ref_overrun), 32'h1);
        check("ovr_req_held", 32'(ref_req), 32'h1);
        check("ovr_cmd", 32'(cmd), 32'(NOP));
        ref_gnt = 1'b1;
        tick();
        check("ovr_ref_cmd", 32'(cmd), 32'(AREF));
        check("ovr_req_drop", 32'(ref_req), 32'h0);
        nref = 0;
        while (cyc < 3700) begin
            tick();
            if (cmd == AREF) nref++;
        end
        check("ovr_single_ref", 32'(nref), 32'h0);
        check("ovr_sticky", 32'(ref_overrun), 32'h1);
`else
        // Refresh disabled: grant toggling must never produce a command or request.
        bad = 0;
        for (int i = 0; i < 5000; i++) begin
            ref_gnt = ~ref_gnt;
            tick();
            if (cmd != NOP || ref_req !== 1'b0 || ref_overrun !== 1'b0 || seq_busy !== 1'b0)
                bad++;
        end
        check("norefresh_bad_cycles", 32'(bad), 32'h0);
        check("norefresh_done", 32'(init_done), 32'h1);
`endif

        // Reset from post-init state clears everything.
        reset = 1'b1;
        tick();
        check_reset_vals("rst_idle");
        reset = 1'b0;
        cyc   = -1;

        // Reset during the power-up wait.
        run_to(300);
        check("pwr_wait_cmd", 32'(cmd), 32'(NOP));
        reset = 1'b1;
        tick();
        check_reset_vals("rst_300");
        reset = 1'b0;
        cyc   = -1;
        run_to(504);
        check("pre_not_early", 32'(cmd), 32'(NOP));
        tick();
        check("pre_after_300", 32'(cmd), 32'(PREC));
        check("pre_addr_after_300", 32'(addr), 32'h400);

        // Reset inside the tRFC window after the first init REF.
        run_to(515);
        check("rfc_win_busy", 32'(seq_busy), 32'h1);
        check("rfc_win_cmd", 32'(cmd), 32'(NOP));
        reset = 1'b1;
        tick();
        check_reset_vals("rst_515");
        reset = 1'b0;
        cyc   = -1;
        run_to(504);
        check("pre_not_early2", 32'(cmd), 32'(NOP));
        tick();
        check("pre_after_515", 32'(cmd), 32'(PREC));
        tick();
        check("nop_after_pre", 32'(cmd), 32'(NOP));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sdram_init_refresh_sequencer.md
Name: sdram_init_refresh_sequencer

Overview:
- Drives the SDRAM command pins during power-up initialisation, then schedules periodic auto-refresh.
- Sits between the Wishbone-facing SDRAM controller datapath and the SDRAM device.
- Owns the command bus until sdr_init_done. After that it only takes the bus for refresh, using a request/grant handshake with the controller's command arbiter.

Parameters:
- T_PWR_CYC, 505, NOP cycles after reset before the first PRECHARGE.
- T_RP, 2, NOP cycles after PRECHARGE.
- T_RFC, 7, NOP cycles after each AUTO REFRESH.
- N_INIT_REF, 2, AUTO REFRESH commands issued during init (must be ≥1).
- T_MRD, 2, NOP cycles after LOAD MODE REGISTER before init done.
- ADDR_W, 13, SDRAM address width.
- MODE_REG, 13'h033, value driven on sdr_addr during LOAD MODE REGISTER.
- REF_INTERVAL, 780, cycles between refresh requests.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- sdr_cs_n  out  1  chip select, active low.
- sdr_ras_n  out  1  RAS, active low.
- sdr_cas_n  out  1  CAS, active low.
- sdr_we_n  out  1  WE, active low.
- sdr_addr  out  ADDR_W  address; A10=1 for PRECHARGE ALL, MODE_REG for LMR, 0 otherwise.
- sdr_ba  out  2  bank address; always 0.
- sdr_init_done  out  1  high once init completes; stays high until reset.
- ref_req  out  1  refresh pending; controller must go idle.
- ref_gnt  in  1  controller idle; sequencer may issue REF.
- seq_busy  out  1  sequencer owns the command bus (init, or refresh REF + tRFC window).
- ref_overrun  out  1  sticky; REF_INTERVAL expired again while ref_req was still pending.

Behaviour:
- All outputs registered.
- Command encoding {cs,ras,cas,we}: NOP=1111 (deselect), PRE=0010, REF=0001, LMR=0000.
- Reset values: command NOP, sdr_addr=0, sdr_ba=0, sdr_init_done=0, ref_req=0, seq_busy=1, ref_overrun=0.
- Cycle 0 is the first edge with reset sampled low. Each command is held exactly one cycle; all other cycles drive NOP.
- Init FSM: PWRUP → PRE → WAIT_RP → REF → WAIT_RFC (loops to REF until N_INIT_REF issued) → LMR → WAIT_MRD → IDLE.
- Init timing:
  - PRE at cycle T_PWR_CYC.
  - REF i (i=0..N_INIT_REF-1) at T_PWR_CYC+1+T_RP+i*(1+T_RFC).
  - LMR one tRFC window after the last REF.
  - sdr_init_done and seq_busy=0 at cycle LMR+1+T_MRD.
  - Defaults: PRE@505, REF@508 and 516, LMR@524, done@527.
- Refresh counter:
  - Starts at 0 on the cycle sdr_init_done rises.
  - On reaching REF_INTERVAL-1: ref_req=1, counter wraps to 0.
- Refresh handshake:
  - ref_req held until ref_gnt is sampled high.
  - The next cycle issues REF, drops ref_req, and sets seq_busy=1 for 1+T_RFC cycles (REF plus T_RFC NOPs).
  - Then IDLE. Counter keeps running; it is not reset by the grant.
- ref_gnt while ref_req=0 is ignored.
- Counter expiry while ref_req=1 sets ref_overrun (sticky until reset); ref_req stays high, and only one REF is issued for that grant.
- Expiry on the same cycle ref_gnt is accepted: the current REF proceeds and ref_req re-asserts the next cycle.
- Reset mid-operation (any state): next edge returns to reset values and PWRUP; the full T_PWR_CYC wait is redone.

Optional Feature:
- SDRAM_PERIODIC_REFRESH_EN
  - Defined: refresh counter, ref_req/ref_gnt handshake and ref_overrun as above.
  - Undefined: after init the FSM stays in IDLE driving NOP; ref_req=0 and ref_overrun=0 constant; ref_gnt is unused; no counter logic.

Decomposition:
- Package sdram_seq_pkg:
  - sdr_cmd_t (4-bit packed {cs,ras,cas,we}).
  - Constants CMD_NOP, CMD_PRE, CMD_REF, CMD_LMR.
  - seq_state_t enum (PWRUP, PRE, WAIT_RP, REF, WAIT_RFC, LMR, WAIT_MRD, IDLE, R_REF, R_WAIT).
- Sub-module sdram_seq_timer: loadable down-counter with a zero flag. The FSM uses it for all wait states; its width is sized for the maximum of T_PWR_CYC, T_RFC and REF_INTERVAL.

Test Plan:
- Defaults, reset released → PRE@505 with addr[10]=1; REF@508 and @516; LMR@524 with addr=13'h033; sdr_init_done rising @527; NOP on every other cycle.
- ref_gnt held high after init → ref_req high at cycle 527+779; REF exactly one cycle after ref_gnt is sampled; seq_busy high for 8 cycles; ref_req low the cycle REF issues.
- ref_gnt held low for 800 cycles after ref_req → ref_overrun=1 at the second expiry, ref_req stays high; granting then yields exactly one REF.
- reset pulsed at cycle 300, then at cycle 515 (inside the tRFC window) → all outputs return to reset values; the next PRE comes exactly 505 cycles after each release.
- N_INIT_REF=8, T_RFC=3 → eight REFs spaced 4 cycles apart; LMR 4 cycles after the last REF.
- SDRAM_PERIODIC_REFRESH_EN undefined, ref_gnt toggled for 5000 cycles after init → only NOP issued; ref_req=0.
